// File: rtl/sqrt_iter_ctrl_pkg.sv
// Shared types and IEEE-754 single-precision field constants for the square-root sequencer.
// Holds the FSM state enumeration plus the special result encodings used on the exception paths.
package sqrt_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EST_WAIT,
        S_EST_CHK,
        S_DIV_REQ,
        S_DIV_WAIT,
        S_ADD_REQ,
        S_ADD_WAIT,
        S_HALVE,
        S_DONE
    } state_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    // True for +0 and -0 alike.
    function automatic logic is_zero_mag(input logic [31:0] v);
        return (v[EXP_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/sqrt_iter_ctrl_if.sv
// Request side plus estimator/divider/adder handshakes of the square-root sequencer.
// master = sequencer, slave = surrounding datapath/requester; SQRT_EARLY_EXIT_EN adds iter_count.
interface sqrt_iter_ctrl_if #(
    parameter int ITER_W = 3
);
    logic        start;
    logic [31:0] in_value;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        incorrect;
`ifdef SQRT_EARLY_EXIT_EN
    logic [ITER_W-1:0] iter_count;
`endif

    logic [31:0] est_value;
    logic [31:0] est_result;
    logic        est_incorrect;

    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_q;

    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_done;
    logic [31:0] add_sum;

    modport master (
        input  start, in_value, est_result, est_incorrect,
               div_done, div_q, add_done, add_sum,
`ifdef SQRT_EARLY_EXIT_EN
        output iter_count,
`endif
        output busy, done, result, incorrect, est_value,
               div_start, div_a, div_b, add_start, add_a, add_b
    );

    modport slave (
        output start, in_value, est_result, est_incorrect,
               div_done, div_q, add_done, add_sum,
`ifdef SQRT_EARLY_EXIT_EN
        input  iter_count,
`endif
        input  busy, done, result, incorrect, est_value,
               div_start, div_a, div_b, add_start, add_a, add_b
    );

endinterface

// File: rtl/sqrt_iter_ctrl_fp_halve.sv
// Divide a non-negative FP magnitude by two via exponent decrement; flush to +0, pass inf/NaN.
// Latency: combinational. Backpressure: none.
module fp_halve
    import sqrt_pkg::*;
(
    input  logic [EXP_MSB:0] mag_in,
    output logic [31:0]      half_out
);

    logic [7:0] exp_in;

    assign exp_in = mag_in[EXP_MSB:EXP_LSB];

    always_comb begin
        half_out = FP_ZERO;
        if (exp_in == EXP_INF) begin
            half_out = {1'b0, exp_in, mag_in[MAN_W-1:0]};
        end else if (exp_in > 8'd1) begin
            // Exponent 1 would land in the denormal range, so it flushes with 0.
            half_out = {1'b0, exp_in - 8'd1, mag_in[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/sqrt_iter_ctrl.sv
// Square-root sequencer: seed from rough_estimate, then Heron iterations on shared FP div/add.
// Latency: 3 cycles on exception paths, 3 + ITERATIONS*(3+Ld+La) otherwise; start ignored unless IDLE.
// Optional SQRT_EARLY_EXIT_EN: stop once x stops changing and expose iter_count.
module sqrt_iter_ctrl
    import sqrt_pkg::*;
#(
    parameter int ITERATIONS = 3,
    parameter int ITER_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    sqrt_iter_ctrl_if.master bus
);

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       q_q, q_d;
    logic [EXP_MSB:0]  s_q, s_d;
    logic [31:0]       res_q, res_d;
    logic              inc_q, inc_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;

    logic [31:0]       x_half;
    logic [ITER_W-1:0] cnt_inc;
    logic              last_iter;
    logic              converged;

    logic busy_c, done_c, div_start_c, add_start_c;

    fp_halve u_fp_halve (
        .mag_in   (s_q),
        .half_out (x_half)
    );

    assign cnt_inc   = cnt_q + ITER_W'(1);
    assign last_iter = (cnt_inc == ITER_W'(ITERATIONS));

`ifdef SQRT_EARLY_EXIT_EN
    assign converged      = (x_half == x_q);
    assign bus.iter_count = cnt_q;
`else
    assign converged      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            x_q     <= '0;
            q_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
            inc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            q_q     <= q_d;
            s_q     <= s_d;
            res_q   <= res_d;
            inc_q   <= inc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        x_d         = x_q;
        q_d         = q_q;
        s_d         = s_q;
        res_d       = res_q;
        inc_d       = inc_q;
        cnt_d       = cnt_q;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        div_start_c = 1'b0;
        add_start_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    a_d     = bus.in_value;
                    cnt_d   = '0;
                    state_d = S_EST_WAIT;
                end
            end
            S_EST_WAIT: state_d = S_EST_CHK;
            S_EST_CHK: begin
                // Estimator flags win over our own sign/zero screening.
                if (bus.est_incorrect) begin
                    res_d   = bus.est_result;
                    inc_d   = 1'b1;
                    state_d = S_DONE;
                end else if (a_q[SIGN_BIT] && !is_zero_mag(a_q)) begin
                    res_d   = FP_QNAN;
                    inc_d   = 1'b1;
                    state_d = S_DONE;
                end else if (is_zero_mag(a_q)) begin
                    res_d   = FP_ZERO;
                    inc_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    x_d     = bus.est_result;
                    cnt_d   = '0;
                    state_d = S_DIV_REQ;
                end
            end
            S_DIV_REQ: begin
                div_start_c = 1'b1;
                state_d     = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (bus.div_done) begin
                    q_d     = bus.div_q;
                    state_d = S_ADD_REQ;
                end
            end
            S_ADD_REQ: begin
                add_start_c = 1'b1;
                state_d     = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (bus.add_done) begin
                    s_d     = bus.add_sum[EXP_MSB:0];
                    state_d = S_HALVE;
                end
            end
            S_HALVE: begin
                x_d   = x_half;
                cnt_d = cnt_inc;
                if (last_iter || converged) begin
                    res_d   = x_half;
                    inc_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV_REQ;
                end
            end
            S_DONE: begin
                busy_c  = 1'b0;
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.result    = res_q;
    assign bus.incorrect = inc_q;
    assign bus.est_value = a_q;
    assign bus.div_start = div_start_c;
    assign bus.div_a     = a_q;
    assign bus.div_b     = x_q;
    assign bus.add_start = add_start_c;
    assign bus.add_a     = x_q;
    assign bus.add_b     = q_q;

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Directed bench for sqrt_iter_ctrl with behavioural estimator, divider and adder (3-cycle wait each).
// Operand/seed pairs are chosen so every quotient and sum is exactly representable.
module tb_sqrt_iter_ctrl;

    localparam int ITERATIONS = 3;
`ifdef SQRT_EARLY_EXIT_EN
    localparam int EXP_IT = 1;
`else
    localparam int EXP_IT = ITERATIONS;
`endif
    localparam int EXP_LAT = 3 + EXP_IT * 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sqrt_iter_ctrl_if #(.ITER_W(3)) bus ();

    sqrt_iter_ctrl #(.ITERATIONS(ITERATIONS), .ITER_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- models ----------------
    function automatic real sp2r(input logic [31:0] v);
        real m;
        int  e;
        if (v[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(v[22:0]) / 8388608.0;
        e = int'(v[30:23]) - 127;
        m = m * (2.0 ** e);
        return v[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic s;
        int   e;
        int   man;
        real  m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0 && e < 200) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > -200) begin m = m * 2.0; e--; end
        man = $rtoi((m - 1.0) * 8388608.0 + 0.5);
        if (man == 8388608) begin man = 0; e++; end
        return {s, 8'(e + 127), man[22:0]};
    endfunction

    function automatic logic est_bad(input logic [31:0] v);
        return (v[30:23] == 8'hFF) || (v[30:23] == 8'h00 && v[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] est_seed(input logic [31:0] v);
        case (v)
            32'h4080_0000: return 32'h4000_0000;  // 4.0  -> 2.0
            32'h4110_0000: return 32'h4040_0000;  // 9.0  -> 3.0
            32'h3E80_0000: return 32'h3F00_0000;  // 0.25 -> 0.5
            32'h7F80_0000: return 32'h7F80_0000;  // +inf marker
            32'h0000_0001: return 32'h1F00_0000;  // denormal marker
            default:       return 32'h3F80_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.est_result    <= est_seed(bus.est_value);
        bus.est_incorrect <= est_bad(bus.est_value);
    end

    int   dcnt = 0, acnt = 0;
    int   div_total = 0, add_total = 0;
    logic div_done_m = 1'b0, add_done_m = 1'b0;
    logic stray_div = 1'b0;

    assign bus.div_done = div_done_m | stray_div;
    assign bus.add_done = add_done_m;

    always @(posedge clk) begin
        div_done_m <= 1'b0;
        if (bus.div_start) begin
            dcnt      <= 2;
            div_total <= div_total + 1;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                div_done_m <= 1'b1;
                bus.div_q  <= (sp2r(bus.div_b) == 0.0) ? 32'h7F80_0000
                                                       : r2sp(sp2r(bus.div_a) / sp2r(bus.div_b));
            end
        end
    end

    always @(posedge clk) begin
        add_done_m <= 1'b0;
        if (bus.add_start) begin
            acnt      <= 2;
            add_total <= add_total + 1;
        end else if (acnt != 0) begin
            acnt <= acnt - 1;
            if (acnt == 1) begin
                add_done_m  <= 1'b1;
                bus.add_sum <= r2sp(sp2r(bus.add_a) + sp2r(bus.add_b));
            end
        end
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic issue(input logic [31:0] val);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_value = val;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Returns cycles since the start cycle (1 = current negedge), -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0)   begin errors++; $display("FAIL rst_result got %h want 0", bus.result); end
        checks++; if (bus.incorrect !== 1'b0) begin errors++; $display("FAIL rst_incorrect got %b want 0", bus.incorrect); end
        checks++; if (bus.div_start !== 1'b0) begin errors++; $display("FAIL rst_div_start got %b want 0", bus.div_start); end
        checks++; if (bus.add_start !== 1'b0) begin errors++; $display("FAIL rst_add_start got %b want 0", bus.add_start); end
        checks++; if (bus.est_value !== 32'h0) begin errors++; $display("FAIL rst_est_value got %h want 0", bus.est_value); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal_four();
        int lat, d0, a0;
        d0 = div_total; a0 = add_total;
        issue(32'h4080_0000);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL norm_busy_c1 got %b want 1", bus.busy); end
        checks++; if (bus.est_value !== 32'h4080_0000) begin errors++; $display("FAIL norm_est_value got %h want 40800000", bus.est_value); end
        wait_done(lat);
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL norm_latency got %0d want %0d", lat, EXP_LAT); end
        checks++; if (bus.result !== 32'h4000_0000) begin errors++; $display("FAIL norm_result got %h want 40000000", bus.result); end
        checks++; if (bus.incorrect !== 1'b0) begin errors++; $display("FAIL norm_incorrect got %b want 0", bus.incorrect); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL norm_busy_done got %b want 0", bus.busy); end
        checks++; if (div_total - d0 != EXP_IT) begin errors++; $display("FAIL norm_div_count got %0d want %0d", div_total - d0, EXP_IT); end
        checks++; if (add_total - a0 != EXP_IT) begin errors++; $display("FAIL norm_add_count got %0d want %0d", add_total - a0, EXP_IT); end
`ifdef SQRT_EARLY_EXIT_EN
        checks++; if (bus.iter_count !== 3'(EXP_IT)) begin errors++; $display("FAIL norm_iter_count got %0d want %0d", bus.iter_count, EXP_IT); end
`endif
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL norm_done_pulse got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h4000_0000) begin errors++; $display("FAIL norm_result_hold got %h want 40000000", bus.result); end
    endtask

    task automatic test_special(input logic [31:0] val, input logic [31:0] exp_res,
                                input logic exp_inc, input string name);
        int lat, d0, a0;
        d0 = div_total; a0 = add_total;
        issue(val);
        wait_done(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL %s_latency got %0d want 3", name, lat); end
        checks++; if (bus.result !== exp_res) begin errors++; $display("FAIL %s_result got %h want %h", name, bus.result, exp_res); end
        checks++; if (bus.incorrect !== exp_inc) begin errors++; $display("FAIL %s_incorrect got %b want %b", name, bus.incorrect, exp_inc); end
        checks++; if ((div_total - d0) + (add_total - a0) != 0) begin errors++; $display("FAIL %s_requests got %0d want 0", name, (div_total - d0) + (add_total - a0)); end
    endtask

    task automatic test_abort_and_recover();
        int lat;
        logic saw_activity;
        issue(32'h4080_0000);
        repeat (3) @(negedge clk);  // now in DIV_WAIT
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.incorrect, bus.div_start, bus.add_start} !== 5'b0)
            begin errors++; $display("FAIL abort_ctrl got %b want 00000", {bus.busy, bus.done, bus.incorrect, bus.div_start, bus.add_start}); end
        checks++; if (bus.result !== 32'h0 || bus.est_value !== 32'h0)
            begin errors++; $display("FAIL abort_regs got %h/%h want 0/0", bus.result, bus.est_value); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray_div = 1'b1;
        @(negedge clk);
        stray_div = 1'b0;
        saw_activity = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy || bus.done || bus.div_start || bus.add_start) saw_activity = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_activity !== 1'b0) begin errors++; $display("FAIL abort_stray got %b want 0", saw_activity); end
        issue(32'h4110_0000);
        wait_done(lat);
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL nine_latency got %0d want %0d", lat, EXP_LAT); end
        checks++; if (bus.result !== 32'h4040_0000) begin errors++; $display("FAIL nine_result got %h want 40400000", bus.result); end
        checks++; if (bus.incorrect !== 1'b0) begin errors++; $display("FAIL nine_incorrect got %b want 0", bus.incorrect); end
    endtask

    task automatic test_start_ignored();
        int lat;
        logic saw_busy;
        issue(32'h3F80_0000);
        repeat (4) @(negedge clk);  // cycle 5
        bus.start    = 1'b1;
        bus.in_value = 32'h4110_0000;
        @(negedge clk);
        bus.start    = 1'b0;
        checks++; if (bus.est_value !== 32'h3F80_0000) begin errors++; $display("FAIL busy_start_operand got %h want 3f800000", bus.est_value); end
        wait_done(lat);
        checks++; if (lat < 0 || lat + 5 != EXP_LAT) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", lat + 5, EXP_LAT); end
        checks++; if (bus.result !== 32'h3F80_0000) begin errors++; $display("FAIL busy_start_result got %h want 3f800000", bus.result); end
        bus.start    = 1'b1;  // held through the DONE cycle
        bus.in_value = 32'h4110_0000;
        @(negedge clk);
        bus.start    = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.busy) saw_busy = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b want 0", saw_busy); end
        checks++; if (bus.est_value !== 32'h3F80_0000) begin errors++; $display("FAIL done_start_operand got %h want 3f800000", bus.est_value); end
        checks++; if (bus.result !== 32'h3F80_0000) begin errors++; $display("FAIL done_start_result got %h want 3f800000", bus.result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(32'h3E80_0000);
        wait_done(lat);
        checks++; if (bus.result !== 32'h3F00_0000) begin errors++; $display("FAIL b2b_quarter got %h want 3f000000", bus.result); end
        issue(32'hBF80_0000);
        wait_done(lat);
        checks++; if (bus.result !== 32'h7FC0_0000 || bus.incorrect !== 1'b1)
            begin errors++; $display("FAIL b2b_negative got %h/%b want 7fc00000/1", bus.result, bus.incorrect); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_value = 32'h0;
        rst_n        = 1'b1;
        test_reset();
        test_normal_four();
        test_special(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
        test_special(32'h8000_0000, 32'h0000_0000, 1'b0, "negzero");
        test_special(32'hBF80_0000, 32'h7FC0_0000, 1'b1, "negative");
        test_special(32'h7F80_0000, 32'h7F80_0000, 1'b1, "inf");
        test_special(32'h0000_0001, 32'h1F00_0000, 1'b1, "denormal");
        test_abort_and_recover();
        test_start_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
